// File: rtl/uio_tx_pkg.sv
// Shared types and frame constants for the UIO UART transmitter.
// The PARITY state exists only when UIO_TX_PARITY_EN is defined.
package uio_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UIO_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_e;

  localparam logic       START_BIT    = 1'b0;
  localparam logic       STOP_BIT     = 1'b1;
  localparam int         DATA_BITS    = 8;
  localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);
  localparam logic [7:0] UIO_OE_ON    = 8'h03;
  localparam logic [7:0] UIO_OE_OFF   = 8'h00;

`ifdef UIO_TX_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/uio_baud_gen.sv
// Bit-period generator: one-cycle tick every CLKS_PER_BIT cycles while run is high.
module uio_baud_gen #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // The tick is registered, so it is raised one count early to land on the last count.
  localparam logic [CNT_W-1:0]  CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count and tick; counter held at zero while idle.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (!run) begin
      cnt_d  = {CNT_W{1'b0}};
      tick_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = {CNT_W{1'b0}};
      tick_d = 1'b0;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
      tick_d = (cnt_q == CNT_PRE);
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= {CNT_W{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uio_uart_tx.sv
// 8N1 UART transmitter driving a two-pin UIO bus (bit0 = line, bit1 = busy).
// Define UIO_TX_PARITY_EN for an 8E1 frame with an even-parity bit.
module uio_uart_tx
  import uio_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  tx_state_e  state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       line_q, line_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;
  logic [7:0] oe_q;
  logic       tick;
  logic       run_s;
  logic       accept_s;

  assign run_s    = (state_q != IDLE);
  assign tx_ready = ready_q & ~rst;
  assign accept_s = tx_valid & tx_ready;

  uio_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .run (run_s),
    .tick(tick)
  );

  // Frame sequencing: next state, latched byte and bit index.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d   = START;
          data_d    = tx_data;
          bit_idx_d = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx_q == LAST_BIT_IDX) begin
`ifdef UIO_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef UIO_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so pins change together with the state register.
  always_comb begin
    line_d = STOP_BIT;
    case (state_d)
      IDLE:    line_d = STOP_BIT;
      START:   line_d = START_BIT;
      DATA:    line_d = data_d[bit_idx_d];
`ifdef UIO_TX_PARITY_EN
      PARITY:  line_d = even_parity(data_d);
`endif
      STOP:    line_d = STOP_BIT;
      default: line_d = STOP_BIT;
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // State and pin registers; reset aborts any frame and idles the line high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= 8'h00;
      bit_idx_q <= 3'd0;
      line_q    <= STOP_BIT;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      oe_q      <= UIO_OE_OFF;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      bit_idx_q <= bit_idx_d;
      line_q    <= line_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      oe_q      <= UIO_OE_ON;
    end
  end

  assign uio_out = {6'b000000, busy_q, line_q};
  assign uio_oe  = oe_q;

endmodule

// File: doc/uio_uart_tx.md
UIO_UART_TX -- requirements
Module: uio_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, giving clock cycles per serial bit (10 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port tx_data, input, 8, byte to transmit; sampled only on acceptance.
REQ-005 SHALL have port tx_valid, input, 1, byte offered.
REQ-006 SHALL have port tx_ready, output, 1, block can accept a byte this cycle.
REQ-007 SHALL have port uio_out, output, 8, pin drive values: bit0 = serial line, bit1 = busy, bits7:2 = 0.
REQ-008 SHALL have port uio_oe, output, 8, pin enables (1 = output).

Function
REQ-009 SHALL use a frame of: start bit (0), 8 data bits LSB first, optional parity bit, stop bit (1); each bit is exactly CLKS_PER_BIT cycles.
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-011 SHALL assert tx_ready only in IDLE and not while rst is high.
REQ-012 SHALL accept a byte when tx_valid && tx_ready; it latches tx_data and enters START on the next edge.
REQ-013 SHALL drive uio_out[0] low starting the cycle after acceptance; zero-cycle combinational path from tx_valid to uio_out is forbidden.
REQ-014 SHALL step START->DATA, DATA->DATA for 8 bits, DATA->PARITY (or STOP if parity compiled out), PARITY->STOP, and STOP->IDLE, each after CLKS_PER_BIT cycles.
REQ-015 SHALL hold uio_out[0] high in IDLE; busy (uio_out[1]) SHALL be 1 in every state except IDLE.
REQ-016 SHALL ignore tx_valid and tx_data changes while not in IDLE; the latched byte alone is serialised.
REQ-017 SHALL, with tx_valid held high continuously, produce start-bit starts exactly N*CLKS_PER_BIT+1 cycles apart, where N is 10 (11 with parity): one IDLE cycle between frames.
REQ-018 SHALL drive uio_oe = 8'h03 in every cycle after reset is released, and uio_out[7:2] = 0 always.
REQ-019 SHALL size the bit-period counter as clog2(CLKS_PER_BIT) bits and the bit index as 3 bits; the counter SHALL wrap to 0 at CLKS_PER_BIT-1 without overflow.

Reset
REQ-020 SHALL, on any edge with rst high, force state IDLE, uio_out = 8'h01, uio_oe = 8'h00, tx_ready = 0, and counters = 0.
REQ-021 SHALL, when rst asserts mid-frame, abort the frame on that edge: line high, byte discarded, no resumption.
REQ-022 SHALL assert tx_ready and uio_oe = 8'h03 on the first edge after rst deasserts.

Configuration
REQ-023 SHALL, when UIO_TX_PARITY_EN is defined, include the PARITY state transmitting even parity (XOR of the 8 data bits), giving an 11-bit frame.
REQ-024 SHALL, when UIO_TX_PARITY_EN is undefined, contain no PARITY state logic and use a 10-bit frame.

Structure
REQ-025 SHALL take the state enum type, the frame constants (START_BIT=0, STOP_BIT=1, DATA_BITS=8) and the uio_oe constant 8'h03 from package uio_tx_pkg.
REQ-026 SHALL generate the bit-period tick in sub-module uio_baud_gen (inputs: clk, rst, run; output: one-cycle tick every CLKS_PER_BIT cycles while run=1, counter cleared while run=0).

Verification (CLKS_PER_BIT=4)
REQ-027 Single byte 8'hA5, no parity: after acceptance, line reads 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit; 40 cycles total; tx_ready returns high on the next cycle.
REQ-028 Parity build, byte 8'h07: parity bit = 1, frame is 44 cycles; byte 8'h03 gives parity bit = 0.
REQ-029 tx_valid held high with bytes 8'h00 then 8'hFF: the two start edges are exactly 41 cycles apart; tx_data changed mid-frame does not alter the bits on the line.
REQ-030 rst pulsed for 1 cycle during data bit 3: line = 1 and uio_oe = 8'h00 on that edge; uio_oe = 8'h03 and tx_ready = 1 on the following edge; no further bits emitted.
REQ-031 Power-up with rst held 5 cycles: uio_out = 8'h01, uio_oe = 8'h00 and tx_ready = 0 throughout, even with tx_valid = 1; no frame starts until after release.
